// File: rtl/rd_sync_ctrl.sv
// rd_sync_ctrl: read-domain side of an asynchronous FIFO.
// It synchronises the Gray write pointer into rclk and advances the read
// pointer on accepted reads. It produces registered empty, almost-empty and
// occupancy status, and flags any synchronised write-pointer step that is
// not a legal single-bit Gray transition.

module rd_sync_ctrl #(
  parameter int ADDRSIZE      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr,
  input  logic                rinc,
  input  logic                err_clr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rq_wptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rcount,
  output logic                sync_err
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] ONE    = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [ADDRSIZE:0] THRESH = PW'(AEMPTY_THRESH);

  // Reject illegal parameterisations at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("rd_sync_ctrl: SYNC_STAGES must be in 2..4");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > (1 << ADDRSIZE) - 1) begin : g_bad_thresh
    $error("rd_sync_ctrl: AEMPTY_THRESH must be in 0..2^ADDRSIZE-1");
  end

  // Synchronizer chain and its previous-sample register.
  logic [ADDRSIZE:0] sync_d [SYNC_STAGES];
  logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
  logic [ADDRSIZE:0] prev_d;
  logic [ADDRSIZE:0] prev_q;

  // Read pointer state and registered status.
  logic [ADDRSIZE:0] rbin_d,   rbin_q;
  logic [ADDRSIZE:0] rptr_d,   rptr_q;
  logic              rempty_d, rempty_q;
  logic              raempty_d, raempty_q;
  logic [ADDRSIZE:0] rcount_d, rcount_q;
  logic              sync_err_d, sync_err_q;

  // Intermediate combinational values.
  logic              rd_accept;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] wdelta;
  logic              gray_viol;

  assign rq_wptr = sync_q[SYNC_STAGES-1];

  // Pure wiring between synchronizer stages; no logic may sit between flops.
  always_comb begin
    for (int i = 0; i < SYNC_STAGES; i++) begin
      sync_d[i] = '0;
    end
    sync_d[0] = wptr;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = rq_wptr;
  end

  // Convert the synchronised Gray write pointer back to binary.
  always_comb begin
    wbin_s = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      wbin_s[i] = ^(rq_wptr >> i);
    end
  end

  // Next read pointer, flags, occupancy and Gray-violation detection.
  always_comb begin
    rd_accept  = rinc & ~rempty_q;
    rbin_next  = rbin_q + (rd_accept ? ONE : '0);
    rgray_next = rbin_next ^ (rbin_next >> 1);

    rbin_d     = rbin_next;
    rptr_d     = rgray_next;
    rempty_d   = (rgray_next == rq_wptr);
    rcount_d   = wbin_s - rbin_next;
    raempty_d  = (rcount_d <= THRESH);

    wdelta     = rq_wptr ^ prev_q;
    gray_viol  = |(wdelta & (wdelta - ONE));
    sync_err_d = gray_viol | (sync_err_q & ~err_clr);
  end

  // Synchronizer stages and previous sample; reset discards in-flight data.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= prev_d;
    end
  end

  // Read pointer and status registers; empty and almost-empty reset asserted.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rempty_q   <= 1'b1;
      raempty_q  <= 1'b1;
      rcount_q   <= '0;
      sync_err_q <= 1'b0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rempty_q   <= rempty_d;
      raempty_q  <= raempty_d;
      rcount_q   <= rcount_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign rptr     = rptr_q;
  assign raddr    = rbin_q[ADDRSIZE-1:0];
  assign rempty   = rempty_q;
  assign raempty  = raempty_q;
  assign rcount   = rcount_q;
  assign sync_err = sync_err_q;

endmodule
